// File: rtl/mmio_pkg.sv
// Shared types and helpers for the MMIO router.
// Region codes name the fixed peripherals on the data port.
package mmio_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] VMEM   = 4'hc;
    localparam logic [3:0] TIMER  = 4'hd;
    localparam logic [3:0] KBD    = 4'he;
    localparam logic [3:0] LOADER = 4'hf;

    localparam int MAX_BE = 128;

    // Reverse the lowest n lanes; upper input lanes must be zero.
    function automatic logic [MAX_BE-1:0] lane_rev(
        input logic [MAX_BE-1:0] be,
        input int unsigned       n
    );
        logic [MAX_BE-1:0] r;
        r = {<<{be}};
        return r >> (MAX_BE - n);
    endfunction

endpackage

// File: rtl/mmio_router_if.sv
// Data-port and peripheral bundle for the MMIO router.
// slave = router view, master = pipeline plus peripherals.
interface mmio_router_if #(
    parameter int NUM_SLAVES = 5,
    parameter int ADDR_W     = 30,
    parameter int DATA_W     = 32
);
    logic                         cpu_read;
    logic                         cpu_write;
    logic [ADDR_W-1:0]            cpu_addr;
    logic [DATA_W-1:0]            cpu_wdata;
    logic [DATA_W/8-1:0]          cpu_be;
    logic [DATA_W-1:0]            cpu_rdata;
    logic                         cpu_stall;
    logic                         cpu_err;
    logic [NUM_SLAVES-1:0]        slv_req;
    logic                         slv_we;
    logic [ADDR_W-1:0]            slv_addr;
    logic [DATA_W-1:0]            slv_wdata;
    logic [DATA_W/8-1:0]          slv_be;
    logic [NUM_SLAVES*DATA_W-1:0] slv_rdata;
    logic [NUM_SLAVES-1:0]        slv_ack;

    modport slave (
        input  cpu_read, cpu_write, cpu_addr, cpu_wdata, cpu_be,
        input  slv_rdata, slv_ack,
        output cpu_rdata, cpu_stall, cpu_err,
        output slv_req, slv_we, slv_addr, slv_wdata, slv_be
    );

    modport master (
        output cpu_read, cpu_write, cpu_addr, cpu_wdata, cpu_be,
        output slv_rdata, slv_ack,
        input  cpu_rdata, cpu_stall, cpu_err,
        input  slv_req, slv_we, slv_addr, slv_wdata, slv_be
    );

endinterface

// File: rtl/mmio_addr_decoder.sv
// Region-code priority match: lowest matching slot wins,
// unmatched addresses fall back to the default slave.
module mmio_addr_decoder #(
    parameter int                              NUM_SLAVES    = 5,
    parameter int                              REGION_BITS   = 4,
    parameter logic [NUM_SLAVES*REGION_BITS-1:0] SLAVE_IDS   = '0,
    parameter int                              DEFAULT_SLAVE = 0,
    parameter int                              SEL_W         = 3
) (
    input  logic [REGION_BITS-1:0] i_region,
    output logic [SEL_W-1:0]       o_sel,
    output logic [NUM_SLAVES-1:0]  o_onehot
);

    always_comb begin
        o_sel = SEL_W'(DEFAULT_SLAVE);
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (i_region == SLAVE_IDS[i*REGION_BITS +: REGION_BITS])
                o_sel = SEL_W'(i);
        end
        o_onehot        = '0;
        o_onehot[o_sel] = 1'b1;
    end

endmodule

// File: rtl/mmio_router.sv
// Routes pipeline data accesses to one of NUM_SLAVES peripherals
// with a wait-for-ack handshake, timeout error and pipeline stall.
module mmio_router
    import mmio_pkg::*;
#(
    parameter int                                NUM_SLAVES    = 5,
    parameter int                                ADDR_W        = 30,
    parameter int                                DATA_W        = 32,
    parameter int                                REGION_BITS   = 4,
    parameter logic [NUM_SLAVES*REGION_BITS-1:0] SLAVE_IDS     =
        {LOADER, KBD, TIMER, VMEM, 4'h0},
    parameter int                                DEFAULT_SLAVE = 0,
    parameter int                                TIMEOUT       = 255,
    parameter logic [NUM_SLAVES-1:0]             LANE_REVERSE  = '0
) (
    input  logic         ui_clk,
    input  logic         rst,
    mmio_router_if.slave bus
);

    localparam int BE_W  = DATA_W / 8;
    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [SEL_W-1:0]      w_sel;
    logic [NUM_SLAVES-1:0] w_onehot;
    logic [BE_W-1:0]       w_be_rev;
    logic [BE_W-1:0]       w_be;
    logic [DATA_W-1:0]     w_slot;
    logic                  w_ack;
    logic                  w_go;

    state_e                r_state;
    logic [SEL_W-1:0]      r_sel;
    logic [CNT_W-1:0]      r_cnt;
    logic [NUM_SLAVES-1:0] r_req;
    logic                  r_we;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [BE_W-1:0]       r_be;
    logic [DATA_W-1:0]     r_rdata;
    logic                  r_err;

    mmio_addr_decoder #(
        .NUM_SLAVES    (NUM_SLAVES),
        .REGION_BITS   (REGION_BITS),
        .SLAVE_IDS     (SLAVE_IDS),
        .DEFAULT_SLAVE (DEFAULT_SLAVE),
        .SEL_W         (SEL_W)
    ) u_dec (
        .i_region (bus.cpu_addr[ADDR_W-1 -: REGION_BITS]),
        .o_sel    (w_sel),
        .o_onehot (w_onehot)
    );

    assign w_go     = bus.cpu_read | bus.cpu_write;
    assign w_be_rev = BE_W'(lane_rev(MAX_BE'(bus.cpu_be), BE_W));
    assign w_be     = LANE_REVERSE[w_sel] ? w_be_rev : bus.cpu_be;
    assign w_slot   = bus.slv_rdata[r_sel*DATA_W +: DATA_W];
    assign w_ack    = bus.slv_ack[r_sel];

    // Stall drops only in DONE, the single cycle the pipeline advances.
    always_ff @(posedge ui_clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_req   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_go) begin
                        r_sel   <= w_sel;
                        r_req   <= w_onehot;
                        r_we    <= bus.cpu_write;
                        r_addr  <= bus.cpu_addr;
                        r_wdata <= bus.cpu_wdata;
                        r_be    <= w_be;
                        r_cnt   <= '0;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_ack) begin
                        if (!r_we) r_rdata <= w_slot;
                        r_req   <= '0;
                        r_state <= DONE;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        if (!r_we) r_rdata <= '0;
                        r_req   <= '0;
                        r_err   <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.cpu_stall = w_go && (r_state != DONE);
    assign bus.cpu_rdata = r_rdata;
    assign bus.cpu_err   = r_err;
    assign bus.slv_req   = r_req;
    assign bus.slv_we    = r_we;
    assign bus.slv_addr  = r_addr;
    assign bus.slv_wdata = r_wdata;
    assign bus.slv_be    = r_be;

endmodule

// File: tb/tb_mmio_router.sv
// Bench for mmio_router: directed table, reset abort, and random
// transactions against a transaction-level reference model.
module tb_mmio_router;

    localparam int NS = 5;
    localparam int AW = 30;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam logic [4:0] LREV = 5'b10010;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mmio_router_if #(.NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();

    mmio_router #(
        .NUM_SLAVES    (NS),
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .REGION_BITS   (4),
        .SLAVE_IDS     ({4'hf, 4'he, 4'hd, 4'hc, 4'h0}),
        .DEFAULT_SLAVE (0),
        .TIMEOUT       (TO),
        .LANE_REVERSE  (LREV)
    ) dut (
        .ui_clk (clk),
        .rst    (rst_n),
        .bus    (bus.slave)
    );

    typedef struct {
        logic        we;
        logic        both;
        logic [29:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        int          dly;
        logic [31:0] rd;
        logic        spur;
        logic        keep;
        logic [4:0]  e_req;
        logic [3:0]  e_be;
        int          e_stall;
        logic        e_err;
        logic [31:0] e_rd;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_rdata = '0;
    int          ids[NS] = '{0, 12, 13, 14, 15};
    vec_t        tbl[7];

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", nm, got, exp);
        end
    endtask

    function automatic int ref_sel(input logic [29:0] a);
        for (int i = 0; i < NS; i++)
            if (int'(a[29:26]) == ids[i]) return i;
        return 0;
    endfunction

    function automatic logic [3:0] ref_be(input int s, input logic [3:0] b);
        logic [3:0] o;
        o = b;
        if (LREV[s])
            for (int j = 0; j < 4; j++) o[j] = b[3-j];
        return o;
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        int sel, oth, nst, w;
        bit done;
        sel = 0;
        for (int i = 0; i < NS; i++) if (v.e_req[i]) sel = i;
        oth = (sel + 1) % NS;
        for (int i = 0; i < NS; i++) bus.slv_rdata[i*DW +: DW] = $urandom;
        bus.slv_rdata[sel*DW +: DW] = v.rd;
        bus.cpu_read  = !v.we || v.both;
        bus.cpu_write = v.we;
        bus.cpu_addr  = v.addr;
        bus.cpu_wdata = v.wd;
        bus.cpu_be    = v.be;
        bus.slv_ack   = '0;
        #1;
        nst  = bus.cpu_stall ? 1 : 0;
        w    = 0;
        done = 0;
        for (int c = 0; c < TO + 20; c++) begin
            @(negedge clk);
            bus.slv_ack = '0;
            if (!bus.cpu_stall) begin
                done = 1;
                break;
            end
            nst++;
            if (bus.slv_req[sel]) begin
                if (w == 0) begin
                    chk({tag, ".req"}, 64'(bus.slv_req), 64'(v.e_req));
                    chk({tag, ".we"}, 64'(bus.slv_we), 64'(v.we));
                    chk({tag, ".addr"}, 64'(bus.slv_addr), 64'(v.addr));
                    chk({tag, ".wdata"}, 64'(bus.slv_wdata), 64'(v.wd));
                    chk({tag, ".be"}, 64'(bus.slv_be), 64'(v.e_be));
                end
                if (w == v.dly) bus.slv_ack[sel] = 1'b1;
                if (v.spur) bus.slv_ack[oth] = 1'b1;
                w++;
            end
        end
        chk({tag, ".done_seen"}, 64'(done), 64'(1));
        chk({tag, ".stall_len"}, 64'(nst), 64'(v.e_stall));
        chk({tag, ".rdata"}, 64'(bus.cpu_rdata), 64'(v.e_rd));
        chk({tag, ".err"}, 64'(bus.cpu_err), 64'(v.e_err));
        chk({tag, ".req_drop"}, 64'(bus.slv_req), 64'(0));
        chk({tag, ".addr_hold"}, 64'(bus.slv_addr), 64'(v.addr));
        chk({tag, ".be_hold"}, 64'(bus.slv_be), 64'(v.e_be));
        m_rdata = v.e_rd;
        if (!v.keep) begin
            bus.cpu_read  = 1'b0;
            bus.cpu_write = 1'b0;
        end
        @(negedge clk);
        chk({tag, ".err_pulse"}, 64'(bus.cpu_err), 64'(0));
        chk({tag, ".idle_stall"}, 64'(bus.cpu_stall), 64'(v.keep));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   k, s;
        bit   tmo;
        logic [3:0] regs[6];
        regs = '{4'h0, 4'h3, 4'hc, 4'hd, 4'he, 4'hf};

        tbl[0] = '{1'b0, 1'b0, 30'h3C00_0010, 32'h0, 4'b0011, 0,
                   32'hCAFE_F00D, 1'b0, 1'b0, 5'b10000, 4'b1100, 2,
                   1'b0, 32'hCAFE_F00D};
        tbl[1] = '{1'b1, 1'b0, 30'h3000_0010, 32'h1234_5678, 4'b0001, 1,
                   32'h5555_5555, 1'b0, 1'b0, 5'b00010, 4'b1000, 3,
                   1'b0, 32'hCAFE_F00D};
        tbl[2] = '{1'b1, 1'b1, 30'h0C00_0040, 32'hA5A5_0F0F, 4'b0110, 5,
                   32'h0, 1'b0, 1'b0, 5'b00001, 4'b0110, 7,
                   1'b0, 32'hCAFE_F00D};
        tbl[3] = '{1'b0, 1'b0, 30'h3400_0000, 32'h0, 4'b1111, -1,
                   32'h1111_2222, 1'b0, 1'b0, 5'b00100, 4'b1111, 9,
                   1'b1, 32'h0};
        tbl[4] = '{1'b0, 1'b0, 30'h0000_0004, 32'h0, 4'b0001, 7,
                   32'h0BAD_BEEF, 1'b0, 1'b0, 5'b00001, 4'b0001, 9,
                   1'b0, 32'h0BAD_BEEF};
        tbl[5] = '{1'b0, 1'b0, 30'h3400_0100, 32'h0, 4'b1000, 2,
                   32'hD00D_0001, 1'b1, 1'b1, 5'b00100, 4'b1000, 4,
                   1'b0, 32'hD00D_0001};
        tbl[6] = '{1'b0, 1'b0, 30'h3800_0200, 32'h0, 4'b1000, 0,
                   32'hEEEE_0002, 1'b1, 1'b0, 5'b01000, 4'b1000, 2,
                   1'b0, 32'hEEEE_0002};

        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.cpu_be    = '0;
        bus.slv_rdata = '0;
        bus.slv_ack   = '0;

        repeat (3) @(negedge clk);
        chk("reset.req", 64'(bus.slv_req), 64'(0));
        chk("reset.we", 64'(bus.slv_we), 64'(0));
        chk("reset.addr", 64'(bus.slv_addr), 64'(0));
        chk("reset.wdata", 64'(bus.slv_wdata), 64'(0));
        chk("reset.be", 64'(bus.slv_be), 64'(0));
        chk("reset.rdata", 64'(bus.cpu_rdata), 64'(0));
        chk("reset.err", 64'(bus.cpu_err), 64'(0));
        chk("reset.stall", 64'(bus.cpu_stall), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // Abort a pending read with reset, then let it restart.
        bus.cpu_read  = 1'b1;
        bus.cpu_write = 1'b0;
        bus.cpu_addr  = 30'h3400_0040;
        bus.cpu_wdata = 32'h7777_8888;
        bus.cpu_be    = 4'b1111;
        repeat (3) @(negedge clk);
        chk("abort.req_pre", 64'(bus.slv_req), 64'(5'b00100));
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort.req", 64'(bus.slv_req), 64'(0));
        chk("abort.we", 64'(bus.slv_we), 64'(0));
        chk("abort.addr", 64'(bus.slv_addr), 64'(0));
        chk("abort.wdata", 64'(bus.slv_wdata), 64'(0));
        chk("abort.be", 64'(bus.slv_be), 64'(0));
        chk("abort.rdata", 64'(bus.cpu_rdata), 64'(0));
        chk("abort.err", 64'(bus.cpu_err), 64'(0));
        rst_n   = 1'b1;
        m_rdata = '0;
        v = '{1'b0, 1'b0, 30'h3400_0040, 32'h7777_8888, 4'b1111, 1,
              32'h0D0D_1234, 1'b0, 1'b0, 5'b00100, 4'b1111, 3,
              1'b0, 32'h0D0D_1234};
        run_txn(v, "restart");

        for (int i = 0; i < 40; i++) begin
            v.we   = 1'($urandom_range(0, 1));
            v.both = v.we & ($urandom_range(0, 3) == 0);
            k      = int'($urandom_range(0, 6));
            v.addr = {(k < 6) ? regs[k] : 4'($urandom), 26'($urandom)};
            v.wd   = $urandom;
            v.be   = 4'($urandom);
            v.dly  = int'($urandom_range(0, TO + 1));
            if (v.dly > TO) v.dly = -1;
            v.rd   = $urandom;
            v.spur = 1'($urandom_range(0, 1));
            v.keep = 1'($urandom_range(0, 1));
            s       = ref_sel(v.addr);
            tmo     = !(v.dly >= 0 && v.dly < TO);
            v.e_req = 5'(1 << s);
            v.e_be  = ref_be(s, v.be);
            v.e_stall = tmo ? TO + 1 : v.dly + 2;
            v.e_err = tmo;
            v.e_rd  = v.we ? m_rdata : (tmo ? 32'h0 : v.rd);
            run_txn(v, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
